// File: rtl/store_word_serialiser_pkg.sv
// Shared definitions for the store serial transmit path: FSM state encoding
// and the widths of the bit-index and gap counters.
package store_word_serialiser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Bit index output width; large enough to address any bit of a 32-bit word.
  localparam int BIT_INDEX_W = 5;

  // Gap counter width; covers inter-word gaps of up to 255 cycles.
  localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/store_gap_timer.sv
// Loadable down-counter with a zero flag. Loading has priority over counting.
// Once at zero it stays there until reloaded.
module store_gap_timer
  import store_word_serialiser_pkg::*;
#(
  parameter int CNT_W = GAP_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load, otherwise decrement until zero is reached.
  always_comb begin
    // NOTE: default assignment first so every path writes count_d; no latch.
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignment so every flop updates from pre-edge values.
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/store_word_serialiser.sv
// Parallel-to-serial word transmitter for the serial store path. Accepts a
// word over a valid/ready handshake, sends it LSB-first one bit per clock with
// strobe, start marker and bit index, then holds the line quiet for
// GAP_CYCLES cycles. All outputs come straight from flops.
module store_word_serialiser
  import store_word_serialiser_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int GAP_CYCLES        = 2,
  // Output delay for timing-annotated simulation; the logic models it as zero.
  parameter int PROPAGATION_DELAY = 15
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WORD_WIDTH-1:0]  DATA,
  input  logic                   LOAD_VALID,
  output logic                   LOAD_READY,
  output logic                   SERIAL_OUT,
  output logic                   BIT_STROBE,
  output logic                   WORD_START,
  output logic [BIT_INDEX_W-1:0] BIT_INDEX,
  output logic                   BUSY,
  output logic                   DONE
);

  // Reject configurations the counters cannot represent.
  if (WORD_WIDTH < 2 || WORD_WIDTH > 32) begin : g_bad_word_width
    $fatal(1, "store_word_serialiser: WORD_WIDTH must be within 2..32");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap_cycles
    $fatal(1, "store_word_serialiser: GAP_CYCLES must be within 0..255");
  end
  if (PROPAGATION_DELAY < 0) begin : g_bad_delay
    $fatal(1, "store_word_serialiser: PROPAGATION_DELAY must not be negative");
  end

  localparam logic [BIT_INDEX_W-1:0] LAST_BIT = BIT_INDEX_W'(WORD_WIDTH - 1);
  // Gap counter starts at GAP_CYCLES-1 so the gap spans exactly GAP_CYCLES cycles.
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_e                 state_q;
  logic [WORD_WIDTH-1:0]  shift_q;
  logic [BIT_INDEX_W-1:0] bit_cnt_q;
  logic                   serial_q;
  logic                   strobe_q;
  logic                   start_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   gap_load;
  logic                   gap_zero;

  // Arm the gap timer on the edge that retires the last bit of a word.
  assign gap_load = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT) && (GAP_CYCLES > 0);

  store_gap_timer #(
    .CNT_W(GAP_CNT_W)
  ) u_gap_timer (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .load_i      (gap_load),
    .load_value_i(GAP_LOAD),
    .zero_o      (gap_zero)
  );

  // Transmit FSM with shift register, bit counter and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b0;
      strobe_q  <= 1'b0;
      start_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // DONE and WORD_START are single-cycle pulses unless re-asserted below.
      done_q  <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (LOAD_VALID && ready_q) begin
            // Bit 0 goes out immediately; the remainder waits in the shifter.
            state_q   <= ST_SHIFT;
            shift_q   <= DATA >> 1;
            serial_q  <= DATA[0];
            strobe_q  <= 1'b1;
            start_q   <= 1'b1;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            serial_q  <= 1'b0;
            strobe_q  <= 1'b0;
            bit_cnt_q <= '0;
            done_q    <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            serial_q  <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          serial_q  <= 1'b0;
          strobe_q  <= 1'b0;
          bit_cnt_q <= '0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign LOAD_READY = ready_q;
  assign SERIAL_OUT = serial_q;
  assign BIT_STROBE = strobe_q;
  assign WORD_START = start_q;
  assign BIT_INDEX  = bit_cnt_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_store_word_serialiser.sv
// Bench for store_word_serialiser. Three instances cover the default
// configuration (32 bits, gap 2), the no-gap configuration (32 bits, gap 0)
// and a short word (4 bits, gap 3). Expected values come from the word being
// sent and the cycle arithmetic of the protocol (bit n appears n cycles after
// the handshake, DONE one cycle after the last bit, period W+G+1).
module tb_store_word_serialiser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  logic [31:0] a_data;
  logic        a_valid, a_ready, a_serial, a_strobe, a_ws, a_busy, a_done;
  logic [4:0]  a_idx;
  // Instance B: no gap
  logic [31:0] b_data;
  logic        b_valid, b_ready, b_serial, b_strobe, b_ws, b_busy, b_done;
  logic [4:0]  b_idx;
  // Instance C: short word
  logic [3:0]  c_data;
  logic        c_valid, c_ready, c_serial, c_strobe, c_ws, c_busy, c_done;
  logic [4:0]  c_idx;

  store_word_serialiser #(.WORD_WIDTH(32), .GAP_CYCLES(2), .PROPAGATION_DELAY(15)) dut_a (
    .CLK(clk), .RESET(rst), .DATA(a_data), .LOAD_VALID(a_valid), .LOAD_READY(a_ready),
    .SERIAL_OUT(a_serial), .BIT_STROBE(a_strobe), .WORD_START(a_ws), .BIT_INDEX(a_idx),
    .BUSY(a_busy), .DONE(a_done));

  store_word_serialiser #(.WORD_WIDTH(32), .GAP_CYCLES(0), .PROPAGATION_DELAY(15)) dut_b (
    .CLK(clk), .RESET(rst), .DATA(b_data), .LOAD_VALID(b_valid), .LOAD_READY(b_ready),
    .SERIAL_OUT(b_serial), .BIT_STROBE(b_strobe), .WORD_START(b_ws), .BIT_INDEX(b_idx),
    .BUSY(b_busy), .DONE(b_done));

  store_word_serialiser #(.WORD_WIDTH(4), .GAP_CYCLES(3), .PROPAGATION_DELAY(15)) dut_c (
    .CLK(clk), .RESET(rst), .DATA(c_data), .LOAD_VALID(c_valid), .LOAD_READY(c_ready),
    .SERIAL_OUT(c_serial), .BIT_STROBE(c_strobe), .WORD_START(c_ws), .BIT_INDEX(c_idx),
    .BUSY(c_busy), .DONE(c_done));

  // Observed output bundles, field order: ready,serial,strobe,start,busy,done,idx
  function automatic logic [10:0] st_a();
    return {a_ready, a_serial, a_strobe, a_ws, a_busy, a_done, a_idx};
  endfunction
  function automatic logic [10:0] st_b();
    return {b_ready, b_serial, b_strobe, b_ws, b_busy, b_done, b_idx};
  endfunction
  function automatic logic [10:0] st_c();
    return {c_ready, c_serial, c_strobe, c_ws, c_busy, c_done, c_idx};
  endfunction
  function automatic logic [10:0] exp_st(input logic ready, input logic serial,
                                         input logic strobe, input logic ws,
                                         input logic busy, input logic done,
                                         input logic [4:0] idx);
    return {ready, serial, strobe, ws, busy, done, idx};
  endfunction

  localparam logic [10:0] IDLE_ST = 11'b100_0000_0000;

  // Present one word to A for a single cycle; A must be idle.
  task automatic load_a(input logic [31:0] w);
    a_data  = w;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    c_valid = 1'b1; c_data = 4'b0110;   // held through reset release
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st_a() !== IDLE_ST) begin
      errors++; $display("FAIL reset_a got %b expected %b", st_a(), IDLE_ST);
    end
    checks++;
    if (st_c() !== IDLE_ST) begin
      errors++; $display("FAIL reset_c_valid_held got %b expected %b", st_c(), IDLE_ST);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st_a() !== IDLE_ST) begin
      errors++; $display("FAIL idle_a got %b expected %b", st_a(), IDLE_ST);
    end
    checks++;
    if (st_b() !== IDLE_ST) begin
      errors++; $display("FAIL idle_b got %b expected %b", st_b(), IDLE_ST);
    end
    // C saw LOAD_VALID on the first edge after release: bit 0 of 4'b0110.
    e = exp_st(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
    checks++;
    if (st_c() !== e) begin
      errors++; $display("FAIL release_handshake_c got %b expected %b", st_c(), e);
    end
    c_valid = 1'b0;
    for (int i = 0; i < 20 && !c_ready; i++) @(negedge clk);
    checks++;
    if (c_ready !== 1'b1) begin
      errors++; $display("FAIL drain_c ready got %b expected 1", c_ready);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [10:0] e;
    w = 32'h8000_0001;
    load_a(w);
    a_data = $urandom;  // must not matter after the handshake
    for (int n = 0; n < 32; n++) begin
      e = exp_st(1'b0, w[n], 1'b1, n == 0, 1'b1, 1'b0, 5'(n));
      checks++;
      if (st_a() !== e) begin
        errors++; $display("FAIL single_bit%0d got %b expected %b", n, st_a(), e);
      end
      @(negedge clk);
    end
    e = exp_st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
    checks++;
    if (st_a() !== e) begin
      errors++; $display("FAIL single_done got %b expected %b", st_a(), e);
    end
    @(negedge clk);
    e = exp_st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    checks++;
    if (st_a() !== e) begin
      errors++; $display("FAIL single_gap2 got %b expected %b", st_a(), e);
    end
    @(negedge clk);
    checks++;
    if (st_a() !== IDLE_ST) begin
      errors++; $display("FAIL single_idle got %b expected %b", st_a(), IDLE_ST);
    end
  endtask

  task automatic test_mid_word_inputs();
    load_a(32'h0);
    for (int n = 0; n < 32; n++) begin
      checks++;
      if ({a_serial, a_strobe, a_idx} !== {1'b0, 1'b1, 5'(n)}) begin
        errors++;
        $display("FAIL midword_bit%0d got serial=%b strobe=%b idx=%0d expected 0,1,%0d",
                 n, a_serial, a_strobe, a_idx, n);
      end
      if (n >= 10) begin
        a_data  = 32'hFFFF_FFFF;
        a_valid = ~a_valid;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 10 && !a_ready; i++) begin
      a_valid = ~a_valid;
      @(negedge clk);
    end
    a_valid = 1'b0;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL midword_ready got %b expected 1", a_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (st_a() !== IDLE_ST) begin
        errors++; $display("FAIL midword_no_extra%0d got %b expected %b", i, st_a(), IDLE_ST);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    logic [10:0] e;
    w = $urandom | 32'h0002_0000;
    load_a(w);
    for (int n = 0; n < 17; n++) @(negedge clk);
    checks++;
    if ({a_serial, a_idx} !== {1'b1, 5'd17}) begin
      errors++; $display("FAIL areset_pre got serial=%b idx=%0d expected 1,17", a_serial, a_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (st_a() !== IDLE_ST) begin
      errors++; $display("FAIL areset_immediate got %b expected %b", st_a(), IDLE_ST);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (st_a() !== IDLE_ST) begin
      errors++; $display("FAIL areset_no_done got %b expected %b", st_a(), IDLE_ST);
    end
    w = $urandom;
    load_a(w);
    for (int n = 0; n < 32; n++) begin
      e = exp_st(1'b0, w[n], 1'b1, n == 0, 1'b1, 1'b0, 5'(n));
      checks++;
      if (st_a() !== e) begin
        errors++; $display("FAIL areset_reload_bit%0d got %b expected %b", n, st_a(), e);
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b1) begin
      errors++; $display("FAIL areset_reload_done got %b expected 1", a_done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    logic [10:0] e;
    int t1, t2;
    w1 = 32'hA5A5_A5A5;
    w2 = 32'h0000_FFFF;
    b_data  = w1;
    b_valid = 1'b1;
    @(negedge clk);
    t1 = cyc;
    b_data = w2;        // next word waits on DATA; ignored until IDLE
    for (int n = 0; n < 32; n++) begin
      e = exp_st(1'b0, w1[n], 1'b1, n == 0, 1'b1, 1'b0, 5'(n));
      checks++;
      if (st_b() !== e) begin
        errors++; $display("FAIL b2b_w1_bit%0d got %b expected %b", n, st_b(), e);
      end
      @(negedge clk);
    end
    e = exp_st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    checks++;
    if (st_b() !== e) begin
      errors++; $display("FAIL b2b_quiet got %b expected %b", st_b(), e);
    end
    @(negedge clk);
    t2 = cyc;
    b_valid = 1'b0;
    checks++;
    if (b_ws !== 1'b1 || (t2 - t1) != 33) begin
      errors++; $display("FAIL b2b_period got start=%b spacing=%0d expected 1,33", b_ws, t2 - t1);
    end
    for (int n = 0; n < 32; n++) begin
      e = exp_st(1'b0, w2[n], 1'b1, n == 0, 1'b1, 1'b0, 5'(n));
      checks++;
      if (st_b() !== e) begin
        errors++; $display("FAIL b2b_w2_bit%0d got %b expected %b", n, st_b(), e);
      end
      @(negedge clk);
    end
    e = exp_st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    checks++;
    if (st_b() !== e) begin
      errors++; $display("FAIL b2b_w2_done got %b expected %b", st_b(), e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (st_b() !== IDLE_ST) begin
        errors++; $display("FAIL b2b_idle%0d got %b expected %b", i, st_b(), IDLE_ST);
      end
    end
  endtask

  // Random words streamed through A with LOAD_VALID held; the model is the
  // word queue plus the W+G+1 start spacing.
  task automatic test_random_stream();
    logic [31:0] q[$];
    logic [31:0] cur;
    int sent, recv, nbit, last_start;
    for (int k = 0; k < 5; k++) q.push_back($urandom);
    sent = 0; recv = 0; nbit = 0; last_start = -1; cur = '0;
    for (int i = 0; i < 400 && recv < 5; i++) begin
      if (a_ws) begin
        if (last_start >= 0) begin
          checks++;
          if ((cyc - last_start) != 35) begin
            errors++; $display("FAIL rand_period got %0d expected 35", cyc - last_start);
          end
        end
        last_start = cyc;
        nbit = 0;
        cur  = '0;
      end
      if (a_strobe) begin
        checks++;
        if (a_idx !== nbit[4:0]) begin
          errors++; $display("FAIL rand_idx got %0d expected %0d", a_idx, nbit);
        end
        if (nbit < 32) cur[nbit] = a_serial;
        nbit++;
      end
      if (a_done) begin
        checks++;
        if (cur !== q[recv] || nbit != 32) begin
          errors++;
          $display("FAIL rand_word%0d got %h (%0d bits) expected %h (32 bits)", recv, cur, nbit, q[recv]);
        end
        recv++;
      end
      if (a_ready) begin
        if (sent < 5) begin
          a_data  = q[sent];
          a_valid = 1'b1;
          sent++;
        end else begin
          a_valid = 1'b0;
        end
      end else begin
        a_data = $urandom;
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    checks++;
    if (recv != 5) begin
      errors++; $display("FAIL rand_timeout got %0d words expected 5", recv);
    end
    for (int i = 0; i < 10 && !a_ready; i++) @(negedge clk);
  endtask

  task automatic test_short_word();
    logic [3:0]  w;
    logic [10:0] e;
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 4'b1010 : 4'($urandom);
      c_data  = w;
      c_valid = 1'b1;
      @(negedge clk);
      c_valid = 1'b0;
      for (int n = 0; n < 4; n++) begin
        e = exp_st(1'b0, w[n], 1'b1, n == 0, 1'b1, 1'b0, 5'(n));
        checks++;
        if (st_c() !== e) begin
          errors++; $display("FAIL short%0d_bit%0d got %b expected %b", k, n, st_c(), e);
        end
        @(negedge clk);
      end
      // DONE rises with the first of three gap cycles; BUSY drops after the third.
      for (int g = 0; g < 3; g++) begin
        e = exp_st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, g == 0, 5'd0);
        checks++;
        if (st_c() !== e) begin
          errors++; $display("FAIL short%0d_gap%0d got %b expected %b", k, g, st_c(), e);
        end
        @(negedge clk);
      end
      checks++;
      if (st_c() !== IDLE_ST) begin
        errors++; $display("FAIL short%0d_idle got %b expected %b", k, st_c(), IDLE_ST);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_mid_word_inputs();
    test_async_reset();
    test_back_to_back();
    test_random_stream();
    test_short_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
